// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (A = ALU, B = load) and the regfile write-port arbiter.
// slave modport is the arbiter side; master is the requester/regfile side.
interface regfile_wb_arbiter_if #(
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          a_valid;
   logic [AW-1:0] a_wn;
   logic [DW-1:0] a_d;
   logic          a_ready;
   logic          b_valid;
   logic [AW-1:0] b_wn;
   logic [DW-1:0] b_d;
   logic          b_ready;
   logic          we;
   logic [AW-1:0] wn;
   logic [DW-1:0] d;
   logic [CW-1:0] a_cnt;
   logic [CW-1:0] b_cnt;
   logic          idle;

   modport slave (
      input  a_valid, a_wn, a_d, b_valid, b_wn, b_d,
      output a_ready, b_ready, we, wn, d, a_cnt, b_cnt, idle
   );

   modport master (
      output a_valid, a_wn, a_d, b_valid, b_wn, b_d,
      input  a_ready, b_ready, we, wn, d, a_cnt, b_cnt, idle
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between two FIFO-buffered writeback sources.
// Define WBARB_R0_DROP_EN to suppress the write enable for granted entries targeting r0.
module regfile_wb_arbiter #(
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned DEPTH = 2
) (
   input logic                 clk,
   input logic                 clr,
   regfile_wb_arbiter_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned EW = AW + DW;

   logic [EW-1:0] mem_q [2][DEPTH];
   logic [PW-1:0] wr_q  [2];
   logic [PW-1:0] rd_q  [2];
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];
   logic [EW-1:0] din   [2];
   logic [EW-1:0] head  [2];
   logic          last_q;
   logic          we_q;
   logic [AW-1:0] wn_q;
   logic [DW-1:0] d_q;

   logic [1:0] valid;
   logic [1:0] ready;
   logic [1:0] nonempty;
   logic [1:0] push;
   logic [1:0] pop;
   logic       grant;
   logic       gnt_b;
   logic       we_d;

   always_comb begin
      valid    = {bus.b_valid, bus.a_valid};
      din[0]   = {bus.a_wn, bus.a_d};
      din[1]   = {bus.b_wn, bus.b_d};
      ready    = '0;
      nonempty = '0;
      push     = '0;
      for (int s = 0; s < 2; s++) begin
         ready[s]    = cnt_q[s] != CW'(DEPTH);
         nonempty[s] = cnt_q[s] != '0;
         push[s]     = valid[s] & ready[s];
         head[s]     = mem_q[s][rd_q[s]];
      end
      // On contention the source not granted last wins
      if (nonempty == 2'b11) pop = last_q ? 2'b01 : 2'b10;
      else                   pop = nonempty;
      grant = |pop;
      gnt_b = pop[1];
      for (int s = 0; s < 2; s++) begin
         cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      end
`ifdef WBARB_R0_DROP_EN
      we_d = grant && (head[gnt_b][EW-1:DW] != '0);
`else
      we_d = grant;
`endif
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int s = 0; s < 2; s++) begin
            wr_q[s]  <= '0;
            rd_q[s]  <= '0;
            cnt_q[s] <= '0;
         end
         last_q <= 1'b1;
         we_q   <= 1'b0;
         wn_q   <= '0;
         d_q    <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
               mem_q[s][wr_q[s]] <= din[s];
               wr_q[s]           <= wr_q[s] + PW'(1);
            end
            if (pop[s]) rd_q[s] <= rd_q[s] + PW'(1);
            cnt_q[s] <= cnt_d[s];
         end
         we_q <= we_d;
         if (grant) last_q <= gnt_b;
         // A dropped r0 entry leaves wn/d untouched, like an idle cycle
         if (we_d) begin
            wn_q <= head[gnt_b][EW-1:DW];
            d_q  <= head[gnt_b][DW-1:0];
         end
      end
   end

   assign bus.a_ready = ready[0];
   assign bus.b_ready = ready[1];
   assign bus.a_cnt   = cnt_q[0];
   assign bus.b_cnt   = cnt_q[1];
   assign bus.we      = we_q;
   assign bus.wn      = wn_q;
   assign bus.d       = d_q;
   assign bus.idle    = ~|nonempty & ~we_q;
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32×32 register file. It shares the single write port (`we`/`wn`/`d`) between two writeback requesters: A (ALU) and B (memory load). Each requester has a valid/ready handshake and a small per-source FIFO. A round-robin scheduler drains the FIFOs onto registered write-port outputs. The block sits between the execute/memory writeback stages and `regfile`.

## Interface
- `DW`, 32, data width.
- `AW`, 5, register-number width.
- `DEPTH`, 2, per-source FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `a_valid`  in  1  A presents a write.
- `a_wn`  in  AW  A destination register.
- `a_d`  in  DW  A write data.
- `a_ready`  out  1  A FIFO not full.
- `b_valid`, `b_wn`, `b_d`, `b_ready`  same as the A ports, for B.
- `we`  out  1  regfile write enable, registered.
- `wn`  out  AW  regfile write register, registered.
- `d`  out  DW  regfile write data, registered.
- `a_cnt`, `b_cnt`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `idle`  out  1  both FIFOs empty and `we`=0.

## Operation
- Accept: a source's entry is pushed at the edge where `x_valid && x_ready`. `x_ready` = (`x_cnt` != DEPTH) and depends on registered state only. It does not combinationally depend on `x_valid` or on a same-cycle pop.
- Each source FIFO preserves order.
- Scheduler state: `last`, a 1-bit flag recording the source last granted (0=A, 1=B).
- Each cycle:
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: the source ≠ `last` is granted.
  - Neither non-empty: no grant, and `last` holds.
- Grant effects at the edge:
  - The head entry is popped.
  - `we`←1, `wn`←head.wn, `d`←head.d.
  - `last`←granted source.
- No grant: `we`←0. `wn`/`d` hold their previous values.
- Push and pop on the same FIFO in the same cycle:
  - Both occur.
  - Occupancy is unchanged.
  - A push into a full FIFO cannot happen, because ready=0.
- Cross-source ordering to the same register equals grant order; the last-granted write wins in the regfile.
- Reset (`clr`=1 at an edge) overrides all other activity, including mid-drain:
  - FIFOs emptied and pending entries discarded.
  - `we`=0, `wn`=0, `d`=0, `last`=1 (so A wins the first tie).
  - `a_ready`=`b_ready`=1, `a_cnt`=`b_cnt`=0, `idle`=1.
  - Inputs presented during the reset cycle are not accepted.
- `idle` is combinational from registered state.

## Timing
- Latency, accept to write:
  - Entry accepted at edge E, FIFO empty, no contention: granted at E+1, so `we` is high during cycle E+1..E+2.
  - The regfile stores the value at edge E+2.
- Throughput: one write per cycle total. Under sustained contention each source gets every other cycle.
- Worst-case wait for a head entry under contention: 1 extra cycle.
- FIFO pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH.
- Ready drops the cycle after the FIFO becomes full. It rises the cycle after a pop from full.

## Configuration
- `WBARB_R0_DROP_EN` defined:
  - An entry whose `wn`=0 is popped when granted but produces `we`=0 for that cycle.
  - It still consumes the grant slot and updates `last`.
- Undefined: writes to register 0 are forwarded like any other, with `we`=1 and `wn`=0. The regfile itself is responsible for r0 semantics.

## Test plan
- Reset: hold `clr`=1 for 2 cycles with both valids high → `we`=0, `wn`=0, `d`=0, `a_ready`=`b_ready`=1, `a_cnt`=`b_cnt`=0, `idle`=1; nothing accepted.
- Single source: A pushes (wn=1,d=0x11) at edge E → `we`=1, `wn`=1, `d`=0x11 at E+1; `we`=0 at E+2; `idle`=1 at E+2.
- Tie after reset: A (wn=3,d=0xA) and B (wn=4,d=0xB) both pushed at edge E →
  - write sequence wn=3 at E+1, wn=4 at E+2;
  - `last`=1 afterwards.
- Same-register conflict: A wn=5,d=1 and B wn=5,d=2 pushed together after reset → writes d=1 then d=2; the regfile read of r5 returns 2.
- Full/backpressure:
  - Hold `a_valid`=1 and `b_valid`=1 for 8 cycles with d counting 0..7 per source → each `x_cnt` saturates at 2.
  - Ready toggles appropriately.
  - Grants alternate A,B,A,B…
  - Per-source write order is strictly increasing; no entry lost or duplicated.
- Reset mid-drain, plus the macro check:
  - Fill both FIFOs, then assert `clr` for one cycle → pending writes never appear; `we`=0 the next cycle.
  - With `WBARB_R0_DROP_EN` defined, push A wn=0 → `we` stays 0 and `a_cnt` returns to 0.
